// File: rtl/roi_pool_if.sv
// Pixel stream in, LeNet write bus and display stream out, for roi_pool_core.
interface roi_pool_if #(parameter int PIX_W = 8);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             sof;
  logic             start;
  logic             mode;
  logic [PIX_W-1:0] threshold;
  logic             disp_valid;
  logic [3:0]       disp_data;
  logic [18:0]      disp_addr;
  logic             lenet_we;
  logic [9:0]       lenet_addr;
  logic [PIX_W-1:0] lenet_dout;
  logic             busy;
  logic             data_ready;

  modport master (
    output pix_valid, pix_data, sof, start, mode, threshold,
    input  disp_valid, disp_data, disp_addr, lenet_we, lenet_addr, lenet_dout, busy, data_ready
  );
  modport slave (
    input  pix_valid, pix_data, sof, start, mode, threshold,
    output disp_valid, disp_data, disp_addr, lenet_we, lenet_addr, lenet_dout, busy, data_ready
  );
endinterface

// File: rtl/roi_pool_core.sv
// Streaming ROI pooler: reduces a centred OUT_N x OUT_N grid of blocks to LeNet
// memory (avg or max) and overlays the pooled preview on a 4-bit display stream.
module roi_pool_core #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int POOL_W     = 8,
  parameter int POOL_H     = 8,
  parameter int OUT_N      = 28,
  parameter int PIX_W      = 8,
  parameter int MEM_BASE   = 66,
  parameter int MEM_STRIDE = 32
) (
  input logic       clk25,
  input logic       rst,
  roi_pool_if.slave bus
);
  localparam int HW    = $clog2(WIDTH);
  localparam int VW    = $clog2(HEIGHT);
  localparam int PWL   = $clog2(POOL_W);
  localparam int PHL   = $clog2(POOL_H);
  localparam int NL    = PWL + PHL;
  localparam int ACC_W = PIX_W + NL;
  localparam int CW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  localparam logic [HW-1:0]  ROI_L    = HW'(WIDTH/2 - POOL_W*OUT_N/2);
  localparam logic [HW-1:0]  ROI_R    = HW'(WIDTH/2 - POOL_W*OUT_N/2 + POOL_W*OUT_N);
  localparam logic [VW-1:0]  ROI_U    = VW'(HEIGHT/2 - POOL_H*OUT_N/2);
  localparam logic [VW-1:0]  ROI_D    = VW'(HEIGHT/2 - POOL_H*OUT_N/2 + POOL_H*OUT_N);
  localparam logic [HW-1:0]  H_LAST   = HW'(WIDTH-1);
  localparam logic [VW-1:0]  V_LAST   = VW'(HEIGHT-1);
  localparam logic [VW-1:0]  PH_V     = VW'(POOL_H);
  localparam logic [CW-1:0]  N_LAST   = CW'(OUT_N-1);
  localparam logic [9:0]     BASE_A   = 10'(MEM_BASE);
  localparam logic [9:0]     STRIDE_A = 10'(MEM_STRIDE);
  localparam logic [18:0]    WIDTH_A  = 19'(WIDTH);
  localparam logic [ACC_W:0] HALF_N   = (ACC_W+1)'((POOL_W*POOL_H)/2);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t                         state;
  logic [HW-1:0]                  h, cur_h, rx;
  logic [VW-1:0]                  v, cur_v, ry;
  logic                           mode_q;
  logic [PIX_W-1:0]               thr_q;
  logic [OUT_N-1:0][ACC_W-1:0]    acc;
  logic [OUT_N-1:0][PIX_W-1:0]    res_hold;
  logic [CW-1:0]                  col, row;
  logic                           in_roi, blk_first, blk_close, cap_pix, show_pool;
  logic [ACC_W-1:0]               pix_ext, acc_cur, acc_next;
  logic [ACC_W:0]                 avg_full;
  logic [PIX_W-1:0]               res_raw, res;

  // sof re-anchors the raster to (0,0) on the very pixel that carries it
  always_comb begin
    cur_h     = bus.sof ? '0 : h;
    cur_v     = bus.sof ? '0 : v;
    in_roi    = (cur_h >= ROI_L) && (cur_h < ROI_R) && (cur_v >= ROI_U) && (cur_v < ROI_D);
    rx        = cur_h - ROI_L;
    ry        = cur_v - ROI_U;
    col       = CW'(rx >> PWL);
    row       = CW'(ry >> PHL);
    blk_first = (rx[PWL-1:0] == '0) && (ry[PHL-1:0] == '0);
    blk_close = (&rx[PWL-1:0]) && (&ry[PHL-1:0]);
    cap_pix   = bus.pix_valid && !bus.sof && (state == CAPTURE) && in_roi;
    show_pool = (state == CAPTURE) && in_roi && (ry >= PH_V);
    pix_ext   = ACC_W'(bus.pix_data);
    acc_cur   = acc[col];
    if (blk_first)   acc_next = pix_ext;
    else if (mode_q) acc_next = (pix_ext > acc_cur) ? pix_ext : acc_cur;
    else             acc_next = acc_cur + pix_ext;
    // result includes the closing pixel, so it is taken from acc_next
    avg_full = ({1'b0, acc_next} + HALF_N) >> NL;
    if (mode_q)                     res_raw = acc_next[PIX_W-1:0];
    else if (|avg_full[ACC_W:PIX_W]) res_raw = '1;
    else                            res_raw = avg_full[PIX_W-1:0];
    res = (res_raw < thr_q) ? '0 : res_raw;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      h              <= '0;
      v              <= '0;
      mode_q         <= 1'b0;
      thr_q          <= '0;
      acc            <= '0;
      res_hold       <= '0;
      bus.disp_valid <= 1'b0;
      bus.disp_data  <= '0;
      bus.disp_addr  <= '0;
      bus.lenet_we   <= 1'b0;
      bus.lenet_addr <= '0;
      bus.lenet_dout <= '0;
      bus.data_ready <= 1'b0;
    end else begin
      bus.lenet_we   <= 1'b0;
      bus.data_ready <= 1'b0;
      bus.disp_valid <= bus.pix_valid;
      if (bus.start && state == IDLE) state <= ARMED;
      if (bus.pix_valid) begin
        if (cur_h == H_LAST) begin
          h <= '0;
          v <= (cur_v == V_LAST) ? '0 : cur_v + 1'b1;
        end else begin
          h <= cur_h + 1'b1;
          v <= cur_v;
        end
        bus.disp_addr <= 19'(cur_v) * WIDTH_A + 19'(cur_h);
        bus.disp_data <= show_pool ? res_hold[col][PIX_W-1 -: 4] : bus.pix_data[PIX_W-1 -: 4];
        // sof while armed starts a capture; while capturing it aborts and restarts
        if (bus.sof && state != IDLE) begin
          state  <= CAPTURE;
          mode_q <= bus.mode;
          thr_q  <= bus.threshold;
          acc    <= '0;
        end else if (cap_pix) begin
          acc[col] <= acc_next;
          if (blk_close) begin
            bus.lenet_we   <= 1'b1;
            bus.lenet_addr <= BASE_A + 10'(col) + STRIDE_A * 10'(row);
            bus.lenet_dout <= res;
            res_hold[col]  <= res;
            if (col == N_LAST && row == N_LAST) begin
              bus.data_ready <= 1'b1;
              state          <= IDLE;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_roi_pool_core.sv
// Bench for roi_pool_core on a reduced frame: block-level reference model,
// write scoreboard with closing-pixel timing, and display-stream checks.
module tb_roi_pool_core;
  localparam int WIDTH = 48, HEIGHT = 32, POOL_W = 4, POOL_H = 2, OUT_N = 6;
  localparam int PIX_W = 8, MEM_BASE = 66, MEM_STRIDE = 32;
  localparam int L = WIDTH/2 - POOL_W*OUT_N/2, R = L + POOL_W*OUT_N;
  localparam int U = HEIGHT/2 - POOL_H*OUT_N/2, D = U + POOL_H*OUT_N;
  localparam int NPIX = POOL_W*POOL_H;

  logic clk25 = 1'b0;
  logic rst;
  roi_pool_if #(.PIX_W(PIX_W)) bus();

  roi_pool_core #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .POOL_W(POOL_W), .POOL_H(POOL_H), .OUT_N(OUT_N),
    .PIX_W(PIX_W), .MEM_BASE(MEM_BASE), .MEM_STRIDE(MEM_STRIDE)
  ) dut (
    .clk25(clk25),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk25 = ~clk25;

  typedef struct { int addr; int data; int ch; int cv; bit last; } wr_t;
  typedef struct { int pat; bit m; int thr; int gap; int exp_val; } vec_t;

  int  n_cmp = 0, n_err = 0;
  int  frame [HEIGHT][WIDTH];
  int  blk_res [OUT_N][OUT_N];
  wr_t exp_q[$];
  int  exp_dr = 0, dr_cnt = 0;
  int  const_exp = -1;
  bit  disp_chk = 1'b0;
  int  drv_h = 0, drv_v = 0;
  bit  prev_valid = 1'b0;
  int  prev_h = 0, prev_v = 0, prev_pix = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic bit in_roi(input int hh, input int vv);
    return hh >= L && hh < R && vv >= U && vv < D;
  endfunction

  task automatic fill_frame(input int pat);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++) begin
        case (pat)
          0:       frame[y][x] = in_roi(x, y) ? 8'h80 : int'($urandom_range(255));
          1:       frame[y][x] = in_roi(x, y) ? 0 : int'($urandom_range(255));
          2:       frame[y][x] = in_roi(x, y) ? 8'hFF : int'($urandom_range(255));
          4:       frame[y][x] = (x * 5) & 8'hFF;
          default: frame[y][x] = int'($urandom_range(255));
        endcase
      end
    if (pat == 1)
      for (int r = 0; r < OUT_N; r++)
        for (int c = 0; c < OUT_N; c++)
          frame[U + r*POOL_H + int'($urandom_range(POOL_H-1))][L + c*POOL_W + int'($urandom_range(POOL_W-1))] = 8'hFF;
  endtask

  // Expected writes for blocks whose closing line lies before 'lines'
  task automatic build_exp(input bit m, input int thr, input int lines);
    for (int r = 0; r < OUT_N; r++)
      for (int c = 0; c < OUT_N; c++) begin
        int sum, mx, avg, res, cv;
        wr_t w;
        cv = U + r*POOL_H + POOL_H - 1;
        if (cv >= lines) continue;
        sum = 0; mx = 0;
        for (int y = 0; y < POOL_H; y++)
          for (int x = 0; x < POOL_W; x++) begin
            int p = frame[U + r*POOL_H + y][L + c*POOL_W + x];
            sum += p;
            if (p > mx) mx = p;
          end
        avg = (sum + NPIX/2) / NPIX;
        if (avg > 255) avg = 255;
        res = m ? mx : avg;
        if (res < thr) res = 0;
        blk_res[r][c] = res;
        w.addr = MEM_BASE + c + MEM_STRIDE*r;
        w.data = res;
        w.ch   = L + c*POOL_W + POOL_W - 1;
        w.cv   = cv;
        w.last = (r == OUT_N-1) && (c == OUT_N-1);
        if (w.last) exp_dr++;
        exp_q.push_back(w);
      end
  endtask

  task automatic idle(input int n);
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.start = 1'b0;
    repeat (n) begin @(posedge clk25); #1; end
  endtask

  task automatic drive_frame(input bit m, input int thr, input int gap, input int stop_line, input int start_line);
    for (int y = 0; y < HEIGHT; y++) begin
      if (y == stop_line) break;
      for (int x = 0; x < WIDTH; x++) begin
        while (int'($urandom_range(99)) < gap) begin
          bus.pix_valid = 1'b0; bus.pix_data = 8'($urandom); bus.sof = 1'($urandom);
          bus.start = 1'b0; bus.mode = 1'($urandom); bus.threshold = 8'($urandom);
          @(posedge clk25); #1;
        end
        bus.pix_valid = 1'b1;
        bus.pix_data  = 8'(frame[y][x]);
        bus.sof       = (y == 0 && x == 0);
        bus.start     = (y == start_line && x == 0);
        if (bus.sof) begin bus.mode = m; bus.threshold = 8'(thr); end
        else begin bus.mode = 1'($urandom); bus.threshold = 8'($urandom); end
        drv_h = x; drv_v = y;
        @(posedge clk25); #1;
      end
    end
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.start = 1'b0;
  endtask

  task automatic arm();
    bus.start = 1'b1;
    @(posedge clk25); #1;
    bus.start = 1'b0;
    check("busy_armed", int'(bus.busy), 1);
  endtask

  task automatic finish_frame(input string tag);
    idle(4);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_data_ready_count"}, dr_cnt, exp_dr);
    check({tag, "_busy_after"}, int'(bus.busy), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_disp_valid"}, int'(bus.disp_valid), 0);
    check({tag, "_disp_data"},  int'(bus.disp_data), 0);
    check({tag, "_disp_addr"},  int'(bus.disp_addr), 0);
    check({tag, "_lenet_we"},   int'(bus.lenet_we), 0);
    check({tag, "_lenet_addr"}, int'(bus.lenet_addr), 0);
    check({tag, "_lenet_dout"}, int'(bus.lenet_dout), 0);
    check({tag, "_busy"},       int'(bus.busy), 0);
    check({tag, "_data_ready"}, int'(bus.data_ready), 0);
  endtask

  // Monitor: outputs at a falling edge answer the inputs seen at the previous falling edge
  initial begin
    wr_t e;
    forever begin
      @(negedge clk25);
      if (!rst) begin
        if (bus.data_ready) dr_cnt++;
        if (bus.lenet_we) begin
          check("we_after_valid", int'(prev_valid), 1);
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL extra_write: addr %0d data 0x%0h, none expected at %0t", bus.lenet_addr, bus.lenet_dout, $time);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", int'(bus.lenet_addr), e.addr);
            check("wr_data", int'(bus.lenet_dout), e.data);
            check("wr_close_h", prev_h, e.ch);
            check("wr_close_v", prev_v, e.cv);
            check("data_ready_on_last", int'(bus.data_ready), int'(e.last));
            if (const_exp >= 0) check("wr_data_const", int'(bus.lenet_dout), const_exp);
          end
        end
        if (disp_chk) begin
          check("disp_valid", int'(bus.disp_valid), int'(prev_valid));
          if (bus.disp_valid) begin
            int exp_d;
            check("disp_addr", int'(bus.disp_addr), prev_v*WIDTH + prev_h);
            if (in_roi(prev_h, prev_v) && prev_v - U >= POOL_H)
              exp_d = blk_res[(prev_v - U)/POOL_H - 1][(prev_h - L)/POOL_W] >> 4;
            else
              exp_d = prev_pix >> 4;
            check("disp_data", int'(bus.disp_data), exp_d);
          end
        end
      end
      prev_valid = bus.pix_valid;
      prev_h     = drv_h;
      prev_v     = drv_v;
      prev_pix   = int'(bus.pix_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.sof = 1'b0; bus.start = 1'b0;
    bus.mode = 1'b0; bus.threshold = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    // pattern: 0 const 0x80, 1 one 0xFF per block, 2 const 0xFF, 3 random; exp_val -1 = model only
    vecs[0] = '{0, 1'b0, 8'h10, 0,  8'h80};
    vecs[1] = '{1, 1'b1, 8'h10, 0,  8'hFF};
    vecs[2] = '{1, 1'b0, 8'h21, 0,  0};
    vecs[3] = '{1, 1'b0, 8'h20, 0,  8'h20};
    vecs[4] = '{0, 1'b0, 8'h10, 30, 8'h80};
    vecs[5] = '{2, 1'b0, 8'h00, 10, 8'hFF};
    vecs[6] = '{0, 1'b0, 8'h81, 0,  0};
    for (int i = 7; i < 10; i++)
      vecs[i] = '{3, 1'($urandom), int'($urandom_range(200)), int'($urandom_range(40)), -1};

    for (int i = 0; i < 10; i++) begin
      fill_frame(vecs[i].pat);
      const_exp = vecs[i].exp_val;
      build_exp(vecs[i].m, vecs[i].thr, HEIGHT);
      arm();
      drive_frame(vecs[i].m, vecs[i].thr, vecs[i].gap, HEIGHT, -1);
      finish_frame($sformatf("vec%0d", i));
      const_exp = -1;
    end

    // sof mid-capture: partial writes, then a full frame with new mode/threshold
    fill_frame(3);
    build_exp(1'b0, 8'h10, U + 5);
    build_exp(1'b1, 8'h30, HEIGHT);
    arm();
    drive_frame(1'b0, 8'h10, 10, U + 5, -1);
    check("abort_no_data_ready", dr_cnt, exp_dr - 1);
    drive_frame(1'b1, 8'h30, 10, HEIGHT, -1);
    finish_frame("abort");

    // async reset mid-capture, then a frame without start produces nothing
    fill_frame(0);
    build_exp(1'b0, 8'h10, U + 5);
    arm();
    drive_frame(1'b0, 8'h10, 0, U + 5, -1);
    rst = 1'b1;
    #2;
    check_outputs_zero("midreset");
    @(posedge clk25); #1;
    rst = 1'b0;
    check("midreset_partial_writes", exp_q.size(), 0);
    idle(2);
    drive_frame(1'b0, 8'h10, 0, HEIGHT, -1);
    finish_frame("noarm");

    // start pulsed while capturing must not re-arm
    build_exp(1'b0, 8'h10, HEIGHT);
    arm();
    drive_frame(1'b0, 8'h10, 0, HEIGHT, U + 3);
    finish_frame("start_ignored");

    // ramp frame with the display stream checked pixel by pixel
    fill_frame(4);
    build_exp(1'b0, 0, HEIGHT);
    check("ramp_blk00_model", blk_res[0][0], ((L*5 + (L+3)*5) * 4 + NPIX/2) / NPIX);
    arm();
    disp_chk = 1'b1;
    drive_frame(1'b0, 0, 20, HEIGHT, -1);
    idle(2);
    disp_chk = 1'b0;
    finish_frame("display");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
